// File: rtl/linear_predict.sv
// linear_predict: sequential dot-product predictor, y_hat = sum(w[k]*x[k]) + b.
// One multiply-accumulate per cycle, result saturated to WIDTH bits and held
// until the consumer takes it.
// Build option: define LINEAR_PREDICT_ROUND_EN to round half up before the
// fractional shift; otherwise the shift truncates toward minus infinity.
module linear_predict #(
    parameter int N_FEATURES = 1,
    parameter int WIDTH      = 32,
    parameter int FRACTION   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_FEATURES*WIDTH-1:0]   x_flat,
    input  logic [N_FEATURES*WIDTH-1:0]   w_flat,
    input  logic [WIDTH-1:0]              b_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              y_hat,
    output logic                          sat_o
);

    // One guard bit beyond the worst-case sum of N full-precision products.
    localparam int AW = 2*WIDTH + $clog2(N_FEATURES) + 1;
    // The counter runs 0..N_FEATURES; the extra count is the output cycle.
    localparam int CW = $clog2(N_FEATURES + 1);
    localparam logic [CW-1:0] LAST = CW'(N_FEATURES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]                      state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic signed [AW-1:0]            acc_q, acc_d;
    logic [N_FEATURES*WIDTH-1:0]     x_q, x_d;
    logic [N_FEATURES*WIDTH-1:0]     w_q, w_d;
    logic [WIDTH-1:0]                y_q, y_d;
    logic                            sat_q, sat_d;
    logic                            ov_q, ov_d;

    logic signed [WIDTH-1:0]         x_lo;
    logic signed [WIDTH-1:0]         w_lo;
    logic signed [2*WIDTH-1:0]       prod;
    logic signed [AW-1:0]            prod_ext;
    logic signed [AW-1:0]            bias_ext;
    logic [WIDTH:0]                  sat_res;

    // Drop the fractional bits, optionally rounding half up first.
    function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] a);
`ifdef LINEAR_PREDICT_ROUND_EN
        logic signed [AW-1:0] rnd;
        rnd = AW'(1) << (FRACTION - 1);
        return (a + rnd) >>> FRACTION;
`else
        return a >>> FRACTION;
`endif
    endfunction

    // Clamp to the signed WIDTH range; MSB of the result is the clamp flag.
    function automatic logic [WIDTH:0] saturate(input logic signed [AW-1:0] v);
        if (v > MAXV) begin
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        end else if (v < MINV) begin
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, v[WIDTH-1:0]};
        end
    endfunction

    // Features and weights are shifted down each MAC cycle, so the active
    // pair always sits in the low word.
    assign x_lo     = x_q[WIDTH-1:0];
    assign w_lo     = w_q[WIDTH-1:0];
    assign prod     = x_lo * w_lo;
    assign prod_ext = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign bias_ext = {{(AW-WIDTH){b_in[WIDTH-1]}}, b_in} <<< FRACTION;
    assign sat_res  = saturate(scale(acc_q));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign y_hat     = y_q;
    assign sat_o     = sat_q;

    // Next-state and datapath control for IDLE -> MAC -> OUT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        x_d     = x_q;
        w_d     = w_q;
        y_d     = y_q;
        sat_d   = sat_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_flat;
                    w_d     = w_flat;
                    cnt_d   = '0;
                    acc_d   = bias_ext;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (cnt_q == LAST) begin
                    sat_d   = sat_res[WIDTH];
                    y_d     = sat_res[WIDTH-1:0];
                    ov_d    = 1'b1;
                    state_d = OUT;
                end else begin
                    acc_d = acc_q + prod_ext;
                    x_d   = x_q >> WIDTH;
                    w_d   = w_q >> WIDTH;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        w_q <= w_d;
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_linear_predict.sv
// Directed bench for linear_predict: one instance with a single feature and
// one with four features, both at Q16.16.
module tb_linear_predict;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Single-feature instance
    logic        rst1_n, iv1, ir1, ov1, or1, sat1;
    logic [31:0] x1, w1, b1, y1;

    // Four-feature instance
    logic         rst4_n, iv4, ir4, ov4, or4, sat4;
    logic [127:0] x4, w4;
    logic [31:0]  b4, y4;

    linear_predict #(.N_FEATURES(1), .WIDTH(32), .FRACTION(16)) u1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1),
        .x_flat(x1), .w_flat(w1), .b_in(b1), .out_valid(ov1),
        .out_ready(or1), .y_hat(y1), .sat_o(sat1)
    );

    linear_predict #(.N_FEATURES(4), .WIDTH(32), .FRACTION(16)) u4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4),
        .x_flat(x4), .w_flat(w4), .b_in(b4), .out_valid(ov4),
        .out_ready(or4), .y_hat(y4), .sat_o(sat4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake on u1 and count edges until out_valid (bounded).
    task automatic run1(input logic [31:0] w, input logic [31:0] x, input logic [31:0] b,
                        output int lat);
        w1 = w; x1 = x; b1 = b; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; x1 = '1; w1 = '1; b1 = '1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ov1) begin lat = i; break; end
        end
    endtask

    task automatic run4(input logic [127:0] w, input logic [127:0] x, input logic [31:0] b,
                        output int lat);
        w4 = w; x4 = x; b4 = b; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; x4 = '1; w4 = '1; b4 = '1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ov4) begin lat = i; break; end
        end
    endtask

    task automatic take1();
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
    endtask

    task automatic take4();
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    int lat;
    logic [31:0] exp_rnd;

    initial begin
        rst1_n = 1'b0; rst4_n = 1'b0;
        iv1 = 1'b0; iv4 = 1'b0; or1 = 1'b0; or4 = 1'b0;
        x1 = '0; w1 = '0; b1 = '0; x4 = '0; w4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1 rst1_n = 1'b1; rst4_n = 1'b1;

        // Reset state
        chk("rst_in_ready1", {31'd0, ir1}, 32'd1);
        chk("rst_out_valid1", {31'd0, ov1}, 32'd0);
        chk("rst_y1", y1, 32'd0);
        chk("rst_sat1", {31'd0, sat1}, 32'd0);
        chk("rst_in_ready4", {31'd0, ir4}, 32'd1);
        chk("rst_out_valid4", {31'd0, ov4}, 32'd0);

        // Basic: 2.0 * 1.5 + 1.0 = 4.0
        run1(32'h0002_0000, 32'h0001_8000, 32'h0001_0000, lat);
        chk("basic_lat", lat, 32'd2);
        chk("basic_y", y1, 32'h0004_0000);
        chk("basic_sat", {31'd0, sat1}, 32'd0);
        chk("basic_busy_ready", {31'd0, ir1}, 32'd0);
        take1();
        chk("basic_consumed_ov", {31'd0, ov1}, 32'd0);
        chk("basic_consumed_ready", {31'd0, ir1}, 32'd1);

        // Positive saturation
        run1(32'h7FFF_0000, 32'h0002_0000, 32'h0, lat);
        chk("satp_y", y1, 32'h7FFF_FFFF);
        chk("satp_sat", {31'd0, sat1}, 32'd1);
        take1();

        // Negative saturation
        run1(32'h7FFF_0000, 32'hFFFE_0000, 32'h0, lat);
        chk("satn_y", y1, 32'h8000_0000);
        chk("satn_sat", {31'd0, sat1}, 32'd1);
        take1();

        // Negative result inside range: -1.5 * 2.0 + 0.25 = -2.75
        run1(32'h0002_0000, 32'hFFFE_8000, 32'h0000_4000, lat);
        chk("neg_y", y1, 32'hFFFD_4000);
        chk("neg_sat", {31'd0, sat1}, 32'd0);
        take1();

        // Rounding: raw product 0x8000 is exactly one half LSB
`ifdef LINEAR_PREDICT_ROUND_EN
        exp_rnd = 32'h0000_0001;
`else
        exp_rnd = 32'h0000_0000;
`endif
        run1(32'h0000_0001, 32'h0000_8000, 32'h0, lat);
        chk("round_y", y1, exp_rnd);
        take1();

        // Dot product: 1+2+3+4 + 0.5 = 10.5
        run4({4{32'h0001_0000}},
             {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
             32'h0000_8000, lat);
        chk("dot_lat", lat, 32'd5);
        chk("dot_y", y4, 32'h000A_8000);
        chk("dot_sat", {31'd0, sat4}, 32'd0);

        // Backpressure: hold the result, ignore a new request
        x4 = {4{32'h0010_0000}}; w4 = {4{32'h0010_0000}}; b4 = 32'h0100_0000;
        iv4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_y", y4, 32'h000A_8000);
            chk("bp_ov", {31'd0, ov4}, 32'd1);
            chk("bp_ready", {31'd0, ir4}, 32'd0);
        end
        iv4 = 1'b0;
        take4();
        chk("bp_consumed_ov", {31'd0, ov4}, 32'd0);
        chk("bp_consumed_ready", {31'd0, ir4}, 32'd1);
        @(posedge clk); #1;
        chk("bp_no_ghost_ready", {31'd0, ir4}, 32'd1);

        // Mixed signs: 0.5*4 + (-1)*3 + 2*(-0.25) + 1*1 - 1 = -1.5
        run4({32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000},
             {32'h0001_0000, 32'hFFFF_C000, 32'h0003_0000, 32'h0004_0000},
             32'hFFFF_0000, lat);
        chk("mix_y", y4, 32'hFFFE_8000);
        take4();

        // Reset during MAC discards the request
        w4 = {4{32'h0001_0000}}; x4 = {4{32'h0005_0000}}; b4 = 32'h0;
        iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b1;
        chk("midrst_ov", {31'd0, ov4}, 32'd0);
        chk("midrst_y", y4, 32'd0);
        chk("midrst_ready", {31'd0, ir4}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_stays_idle", {31'd0, ov4}, 32'd0);

        // Request after reset: 4 * 0.5 * 3.0 = 6.0
        run4({4{32'h0000_8000}}, {4{32'h0003_0000}}, 32'h0, lat);
        chk("postrst_lat", lat, 32'd5);
        chk("postrst_y", y4, 32'h0006_0000);
        take4();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/linear_predict.md
LINEAR_PREDICT -- requirements
Module: linear_predict

Interface
REQ-001 SHALL have parameter N_FEATURES, default 1: number of features, at least 1.
REQ-002 SHALL have parameter WIDTH, default 32: word width of every signed fixed-point value.
REQ-003 SHALL have parameter FRACTION, default 16: fractional bits (Q16.16 at defaults).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: request valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-008 SHALL have port x_flat, input, N_FEATURES*WIDTH bits: features; feature k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port w_flat, input, N_FEATURES*WIDTH bits: weights, packed the same way as x_flat.
REQ-010 SHALL have port b_in, input, WIDTH bits: bias.
REQ-011 SHALL have port out_valid, output, 1 bit: y_hat valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream (sgd_update feeder) accepts the result.
REQ-013 SHALL have port y_hat, output, WIDTH bits: prediction y_hat = sum(w[k]*x[k]) + b.
REQ-014 SHALL have port sat_o, output, 1 bit: y_hat was clamped; qualified by out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, MAC and OUT.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 A handshake (in_valid & in_ready) SHALL register x_flat, w_flat and b_in, clear the feature counter, load the accumulator with b_in<<FRACTION, and move to MAC.
REQ-018 Inputs SHALL be ignored outside the handshake cycle.
REQ-019 MAC SHALL add the full-precision 2*WIDTH signed product w[k]*x[k] for exactly one feature per cycle, k = 0..N_FEATURES-1.
REQ-020 After feature N_FEATURES-1, MAC SHALL move to OUT.
REQ-021 Accumulator width SHALL be 2*WIDTH + clog2(N_FEATURES) + 1 bits, so it never overflows internally.
REQ-022 Leaving MAC SHALL register y_hat = saturate(acc >>> FRACTION) and set out_valid=1.
REQ-023 Saturation SHALL clamp to the most-positive signed WIDTH value (0x7FFFFFFF) or the most-negative (0x80000000) and set sat_o=1; otherwise sat_o=0.
REQ-024 Latency SHALL be N_FEATURES+1 rising edges from the handshake edge to out_valid=1.
REQ-025 In OUT, y_hat, sat_o and out_valid SHALL hold stable until out_valid & out_ready; that edge SHALL return the FSM to IDLE and clear out_valid.
REQ-026 A new request SHALL be accepted no earlier than the cycle after the result is consumed (no overlap).
REQ-027 in_valid asserted in any state other than IDLE SHALL have no effect.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE from any state, including mid-MAC and OUT.
REQ-029 Reset SHALL set out_valid=0, y_hat=0, sat_o=0, accumulator=0 and counter=0; the in-flight request SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Configuration
REQ-031 Macro LINEAR_PREDICT_ROUND_EN SHALL select the rounding mode.
REQ-032 With LINEAR_PREDICT_ROUND_EN defined, 2^(FRACTION-1) SHALL be added to the accumulator before the arithmetic right shift (round half up).
REQ-033 Without LINEAR_PREDICT_ROUND_EN, the shift SHALL truncate (floor toward minus infinity).
REQ-034 Rounding SHALL be applied before saturation in both modes.

Verification
REQ-035 Basic: N=1, w=0x00020000, x=0x00018000, b=0x00010000 -> y_hat=0x00040000, sat_o=0, out_valid exactly 2 edges after the handshake.
REQ-036 Dot product: N=4, x={1.0,2.0,3.0,4.0}, w all 1.0, b=0x00008000 -> y_hat=0x000A8000, out_valid 5 edges after the handshake.
REQ-037 Saturation: N=1, w=0x7FFF0000, x=0x00020000, b=0 -> y_hat=0x7FFFFFFF, sat_o=1; same with x=0xFFFE0000 -> y_hat=0x80000000, sat_o=1.
REQ-038 Rounding: N=1, w=0x00000001, x=0x00008000, b=0 -> y_hat=0x00000001 with the macro defined, 0x00000000 without.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> y_hat stable, in_ready=0, a second in_valid ignored; result consumed on the first out_ready=1 edge, then in_ready=1.
REQ-040 Reset mid-operation: rst_n=0 for one edge during MAC (N=4) -> next cycle out_valid=0, y_hat=0, in_ready=1; a subsequent request computes correctly.
